// File: rtl/ac_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : ac_bank_if
//  Description : Bundle of per-channel control/data and the dump stream port
//                of the accumulator bank. The slave modport is the bank side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ac_bank_if #(
   parameter int DATA_W = 16,
   parameter int N_CH   = 4
);
   localparam int CH_W = $clog2(N_CH);

   logic [N_CH-1:0]        write_en;
   logic [N_CH-1:0]        alu_to_ac;
   logic [N_CH-1:0]        acc_en;
   logic [N_CH-1:0]        clear;
   logic [N_CH*DATA_W-1:0] datain;
   logic [N_CH*DATA_W-1:0] datain_alu;
   logic [N_CH*DATA_W-1:0] dataout;
   logic [N_CH-1:0]        ovf;
   logic                   dump_req;
   logic                   dump_busy;
   logic                   dump_valid;
   logic                   dump_ready;
   logic [DATA_W-1:0]      dump_data;
   logic [CH_W-1:0]        dump_ch;
   logic                   dump_last;

   modport slave (
      input  write_en, alu_to_ac, acc_en, clear, datain, datain_alu,
      input  dump_req, dump_ready,
      output dataout, ovf, dump_busy, dump_valid, dump_data, dump_ch, dump_last
   );

   modport master (
      output write_en, alu_to_ac, acc_en, clear, datain, datain_alu,
      output dump_req, dump_ready,
      input  dataout, ovf, dump_busy, dump_valid, dump_data, dump_ch, dump_last
   );
endinterface
`default_nettype wire

// File: rtl/ac_bank.sv
`default_nettype none
// ============================================================================
//  Module      : ac_bank
//  Description : Bank of N_CH signed accumulators (one per core) with sticky
//                overflow flags and a snapshot dump sequencer that streams all
//                channels over a single valid/ready port.
//                Optional macro AC_SATURATE_EN: clamp on accumulate overflow
//                instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module ac_bank #(
   parameter int DATA_W = 16,
   parameter int N_CH   = 4
) (
   input  wire logic  clock,
   input  wire logic  rst_n,
   ac_bank_if.slave   bus
);
   localparam int CH_W = $clog2(N_CH);
   localparam logic [CH_W-1:0]   C_LAST_IDX = CH_W'(N_CH - 1);
   localparam logic [DATA_W-1:0] C_SMAX     = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] C_SMIN     = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   logic [DATA_W-1:0] r_acc     [N_CH];
   logic [DATA_W-1:0] w_acc_nxt [N_CH];
   logic [DATA_W-1:0] w_addend  [N_CH];
   logic [DATA_W-1:0] w_sum     [N_CH];
   logic [N_CH-1:0]   w_add_ovf;
   logic [N_CH-1:0]   r_ovf;
   logic [N_CH-1:0]   w_ovf_nxt;

   logic [DATA_W-1:0] r_shadow  [N_CH];
   state_t            r_state;
   logic [CH_W-1:0]   r_idx;
   logic [CH_W-1:0]   w_idx_inc;
   logic              r_valid;
   logic              r_busy;
   logic              r_last;
   logic [DATA_W-1:0] r_data;
   logic [CH_W-1:0]   r_ch;

   // Per-channel next value: clear > alu_to_ac > acc_en > write_en.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         w_addend[i]  = bus.datain_alu[i*DATA_W +: DATA_W];
         w_sum[i]     = r_acc[i] + w_addend[i];
         // Signed overflow: same-sign operands producing a different-sign sum.
         w_add_ovf[i] = (r_acc[i][DATA_W-1] == w_addend[i][DATA_W-1]) &&
                        (w_sum[i][DATA_W-1] != r_acc[i][DATA_W-1]);
         w_acc_nxt[i] = r_acc[i];
         w_ovf_nxt[i] = r_ovf[i];
         if (bus.clear[i]) begin
            w_acc_nxt[i] = '0;
            w_ovf_nxt[i] = 1'b0;
         end else if (bus.alu_to_ac[i]) begin
            w_acc_nxt[i] = w_addend[i];
         end else if (bus.acc_en[i]) begin
            w_ovf_nxt[i] = r_ovf[i] | w_add_ovf[i];
`ifdef AC_SATURATE_EN
            if (w_add_ovf[i]) begin
               w_acc_nxt[i] = r_acc[i][DATA_W-1] ? C_SMIN : C_SMAX;
            end else begin
               w_acc_nxt[i] = w_sum[i];
            end
`else
            w_acc_nxt[i] = w_sum[i];
`endif
         end else if (bus.write_en[i]) begin
            w_acc_nxt[i] = bus.datain[i*DATA_W +: DATA_W];
         end
      end
   end

   // Accumulator and sticky overflow registers.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            r_acc[i] <= '0;
         end
         r_ovf <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            r_acc[i] <= w_acc_nxt[i];
         end
         r_ovf <= w_ovf_nxt;
      end
   end

   assign w_idx_inc = r_idx + 1'b1;

   // Dump sequencer: snapshot on request, then one beat per accepted handshake.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_last  <= 1'b0;
         r_data  <= '0;
         r_ch    <= '0;
         for (int i = 0; i < N_CH; i++) begin
            r_shadow[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.dump_req) begin
                  // Capture post-edge values so same-cycle writes are included.
                  for (int i = 0; i < N_CH; i++) begin
                     r_shadow[i] <= w_acc_nxt[i];
                  end
                  r_idx   <= '0;
                  r_data  <= w_acc_nxt[0];
                  r_ch    <= '0;
                  r_last  <= 1'b0;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_SEND;
               end
            end
            S_SEND: begin
               if (r_valid && bus.dump_ready) begin
                  if (r_last) begin
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_last  <= 1'b0;
                     r_state <= S_IDLE;
                  end else begin
                     r_idx   <= w_idx_inc;
                     r_data  <= r_shadow[w_idx_inc];
                     r_ch    <= w_idx_inc;
                     r_last  <= (w_idx_inc == C_LAST_IDX);
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_last  <= 1'b0;
            end
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_out
         assign bus.dataout[gi*DATA_W +: DATA_W] = r_acc[gi];
      end
   endgenerate

   assign bus.ovf        = r_ovf;
   assign bus.dump_busy  = r_busy;
   assign bus.dump_valid = r_valid;
   assign bus.dump_data  = r_data;
   assign bus.dump_ch    = r_ch;
   assign bus.dump_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_ac_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ac_bank
//  Description : Self-checking bench for ac_bank: directed scenarios followed
//                by randomized traffic, compared each cycle against a signed
//                integer model with a beat queue for the dump stream.
//                Honours AC_SATURATE_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ac_bank;
   localparam int W = 16;
   localparam int N = 4;
   localparam longint MOD  = longint'(1) << W;
   localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
   localparam longint MINS = -(longint'(1) << (W - 1));

   logic clock;
   logic rst_n;

   ac_bank_if #(.DATA_W(W), .N_CH(N)) bus ();

   ac_bank #(.DATA_W(W), .N_CH(N)) dut (
      .clock (clock),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // Reference state: unsigned channel values, sticky flags, pending beats.
   longint m_acc [N];
   bit     m_ovf [N];
   longint q [$];

   function automatic longint to_signed(input longint u);
      return (u > MAXS) ? u - MOD : u;
   endfunction

   function automatic longint to_unsigned(input longint s);
      return ((s % MOD) + MOD) % MOD;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.write_en   = '0;
      bus.alu_to_ac  = '0;
      bus.acc_en     = '0;
      bus.clear      = '0;
      bus.datain     = '0;
      bus.datain_alu = '0;
      bus.dump_req   = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_acc[i] = 0;
         m_ovf[i] = 1'b0;
      end
      q.delete();
   endtask

   task automatic check_state();
      logic [W-1:0] e;
      for (int i = 0; i < N; i++) begin
         e = W'(m_acc[i]);
         chk($sformatf("ch%0d", i), 64'(bus.dataout[i*W +: W]), 64'(e));
         chk($sformatf("ovf%0d", i), 64'(bus.ovf[i]), 64'(m_ovf[i]));
      end
      chk("dump_busy", 64'(bus.dump_busy), 64'(q.size() > 0));
      chk("dump_valid", 64'(bus.dump_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
         e = W'(q[0]);
         chk("dump_data", 64'(bus.dump_data), 64'(e));
         chk("dump_ch", 64'(bus.dump_ch), 64'(N - q.size()));
         chk("dump_last", 64'(bus.dump_last), 64'(q.size() == 1));
      end else begin
         chk("dump_last_idle", 64'(bus.dump_last), 64'd0);
      end
   endtask

   // Apply the current inputs to the model, then advance one clock and compare.
   task automatic tick();
      longint nxt [N];
      longint a, b, s;
      bit     accepted;
      accepted = (q.size() > 0) && bus.dump_ready;
      for (int i = 0; i < N; i++) begin
         nxt[i] = m_acc[i];
         b = longint'(bus.datain_alu[i*W +: W]);
         if (bus.clear[i]) begin
            nxt[i]   = 0;
            m_ovf[i] = 1'b0;
         end else if (bus.alu_to_ac[i]) begin
            nxt[i] = b;
         end else if (bus.acc_en[i]) begin
            a = to_signed(m_acc[i]);
            s = a + to_signed(b);
            if (s > MAXS || s < MINS) begin
               m_ovf[i] = 1'b1;
`ifdef AC_SATURATE_EN
               s = (s > MAXS) ? MAXS : MINS;
`endif
            end
            nxt[i] = to_unsigned(s);
         end else if (bus.write_en[i]) begin
            nxt[i] = longint'(bus.datain[i*W +: W]);
         end
      end
      if (q.size() == 0) begin
         if (bus.dump_req) begin
            for (int i = 0; i < N; i++) q.push_back(nxt[i]);
         end
      end else if (accepted) begin
         void'(q.pop_front());
      end
      for (int i = 0; i < N; i++) m_acc[i] = nxt[i];
      @(posedge clock);
      #1;
      check_state();
   endtask

   initial begin
      logic [W-1:0] v;
      int ready_pat [10] = '{1, 0, 0, 1, 0, 1, 0, 1, 1, 1};

      rst_n = 1'b0;
      clear_inputs();
      bus.dump_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      // Reset state, explicit constants.
      chk("rst_dataout", 64'(bus.dataout), 64'd0);
      chk("rst_ovf", 64'(bus.ovf), 64'd0);
      chk("rst_busy", 64'(bus.dump_busy), 64'd0);
      chk("rst_valid", 64'(bus.dump_valid), 64'd0);
      chk("rst_last", 64'(bus.dump_last), 64'd0);
      chk("rst_data", 64'(bus.dump_data), 64'd0);
      chk("rst_ch", 64'(bus.dump_ch), 64'd0);
      rst_n = 1'b1;

      // Bus load, then ALU load winning over a same-cycle bus load.
      bus.write_en[0] = 1'b1;
      bus.datain[0 +: W] = 16'h1234;
      tick();
      chk("tp1_load", 64'(bus.dataout[0 +: W]), 64'h1234);
      bus.alu_to_ac[0] = 1'b1;
      bus.datain[0 +: W] = 16'h5555;
      bus.datain_alu[0 +: W] = 16'h00AA;
      tick();
      chk("tp1_alu_wins", 64'(bus.dataout[0 +: W]), 64'h00AA);
      chk("tp1_others", 64'(bus.dataout[N*W-1:W]), 64'd0);
      clear_inputs();

      // Positive overflow, then clear beating accumulate.
      bus.write_en[1] = 1'b1;
      bus.datain[W +: W] = 16'h7FF0;
      tick();
      clear_inputs();
      bus.acc_en[1] = 1'b1;
      bus.datain_alu[W +: W] = 16'h0020;
      tick();
      chk("tp2_ovf", 64'(bus.ovf[1]), 64'd1);
`ifdef AC_SATURATE_EN
      chk("tp2_val", 64'(bus.dataout[W +: W]), 64'h7FFF);
`else
      chk("tp2_val", 64'(bus.dataout[W +: W]), 64'h8010);
`endif
      bus.clear[1] = 1'b1;
      tick();
      chk("tp2_clr_val", 64'(bus.dataout[W +: W]), 64'd0);
      chk("tp2_clr_ovf", 64'(bus.ovf[1]), 64'd0);
      clear_inputs();

      // Full-rate dump of known channel contents.
      bus.write_en = '1;
      bus.datain = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
      tick();
      clear_inputs();
      bus.dump_req = 1'b1;
      bus.dump_ready = 1'b1;
      tick();
      bus.dump_req = 1'b0;
      for (int k = 0; k < N; k++) begin
         v = W'((k + 1) * 16'h0011);
         chk($sformatf("tp3_data%0d", k), 64'(bus.dump_data), 64'(v));
         chk($sformatf("tp3_ch%0d", k), 64'(bus.dump_ch), 64'(k));
         chk($sformatf("tp3_last%0d", k), 64'(bus.dump_last), 64'(k == N - 1));
         tick();
      end
      chk("tp3_busy_done", 64'(bus.dump_busy), 64'd0);

      // Stalled dump with a live write to ch2 and an ignored mid-dump request.
      bus.dump_req = 1'b1;
      bus.dump_ready = 1'b0;
      tick();
      bus.dump_req = 1'b0;
      for (int k = 0; k < 10; k++) begin
         bus.dump_ready = ready_pat[k][0];
         bus.write_en   = '0;
         bus.dump_req   = 1'b0;
         if (k == 1) begin
            bus.write_en[2] = 1'b1;
            bus.datain[2*W +: W] = 16'hBEEF;
         end
         if (k == 3) bus.dump_req = 1'b1;
         if (q.size() == N - 2) chk("tp4_beat2", 64'(bus.dump_data), 64'h0033);
         tick();
      end
      chk("tp4_ch2_live", 64'(bus.dataout[2*W +: W]), 64'hBEEF);
      chk("tp4_idle", 64'(bus.dump_busy), 64'd0);
      clear_inputs();

      // Randomized traffic biased toward overflow-prone operands.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < N; i++) begin
            bus.write_en[i]  = ($urandom_range(0, 2) == 0);
            bus.alu_to_ac[i] = ($urandom_range(0, 5) == 0);
            bus.acc_en[i]    = ($urandom_range(0, 1) == 0);
            bus.clear[i]     = ($urandom_range(0, 9) == 0);
            bus.datain[i*W +: W] = W'($urandom);
            case ($urandom_range(0, 2))
               0:       bus.datain_alu[i*W +: W] = W'($urandom_range(16'h7000, 16'h7FFF));
               1:       bus.datain_alu[i*W +: W] = W'($urandom_range(16'h8000, 16'h8FFF));
               default: bus.datain_alu[i*W +: W] = W'($urandom);
            endcase
         end
         bus.dump_req   = ($urandom_range(0, 5) == 0);
         bus.dump_ready = ($urandom_range(0, 1) == 0);
         tick();
      end
      clear_inputs();

      // Drain, load nonzero values, start a dump and reset during beat 1.
      bus.dump_ready = 1'b1;
      repeat (N + 1) tick();
      bus.write_en = '1;
      bus.datain = {16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
      bus.dump_req = 1'b1;
      tick();
      clear_inputs();
      tick();
      chk("tp5_beat1_ch", 64'(bus.dump_ch), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("tp5_async_dataout", 64'(bus.dataout), 64'd0);
      chk("tp5_async_ovf", 64'(bus.ovf), 64'd0);
      chk("tp5_async_valid", 64'(bus.dump_valid), 64'd0);
      chk("tp5_async_busy", 64'(bus.dump_busy), 64'd0);
      chk("tp5_async_last", 64'(bus.dump_last), 64'd0);
      chk("tp5_async_data", 64'(bus.dump_data), 64'd0);
      chk("tp5_async_ch", 64'(bus.dump_ch), 64'd0);
      model_reset();
      @(posedge clock);
      #1;
      rst_n = 1'b1;
      bus.dump_req = 1'b1;
      tick();
      bus.dump_req = 1'b0;
      for (int k = 0; k < N; k++) begin
         chk($sformatf("tp5_zero%0d", k), 64'(bus.dump_data), 64'd0);
         tick();
      end
      chk("tp5_done", 64'(bus.dump_busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
